// File: rtl/req_index_encoder_if.sv
// Request/grant bundle for req_index_encoder.
// master: request source and grant consumer; slave: the encoder itself.
interface req_index_encoder_if;
  logic [15:0] req_in;
  logic        out_ready;
  logic [3:0]  idx_out;
  logic        out_valid;
  logic [15:0] pending;
  logic        overflow;

  modport master (
    output req_in, out_ready,
    input  idx_out, out_valid, pending, overflow
  );

  modport slave (
    input  req_in, out_ready,
    output idx_out, out_valid, pending, overflow
  );
endinterface

// File: rtl/req_index_encoder.sv
// req_index_encoder: collects 16 request pulses into a pending vector and
// grants them one at a time, round-robin, as a binary index over a
// valid/ready handshake.
// Optional macro RRE_BACK_TO_BACK_EN: on accept, load the next grant right
// away instead of passing through IDLE (one grant per cycle).
//
// state | meaning
// IDLE  | no grant offered; picks the next pending index when there is one
// HOLD  | idx_out offered with out_valid=1 until accepted
module req_index_encoder #(
  parameter logic [3:0] ROT_START = 4'd0
) (
  input logic              clk,
  input logic              rst,
  req_index_encoder_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] pending_q, pending_d;
  logic        overflow_q, overflow_d;
  logic        accept;
  logic [15:0] served;

  // First set bit of vec at or above start, wrapping 15->0.
  // Scanning offsets downward lets the smallest offset win.
  function automatic logic [3:0] rr_pick(input logic [15:0] vec, input logic [3:0] start);
    logic [3:0] pick;
    logic [3:0] cand;
    pick = start;
    for (int i = 15; i >= 0; i--) begin
      cand = start + 4'(i);
      if (vec[cand]) pick = cand;
    end
    return pick;
  endfunction

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= ROT_START;
      idx_q      <= 4'h0;
      pending_q  <= 16'h0000;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // Next state, grant index and round-robin pointer
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (pending_q != 16'h0000) begin
          idx_d   = rr_pick(pending_q, ptr_q);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          ptr_d   = idx_q + 4'd1;
`ifdef RRE_BACK_TO_BACK_EN
          // Only bits already pending (not this cycle's req_in) are eligible.
          if ((pending_q & ~served) != 16'h0000) begin
            idx_d   = rr_pick(pending_q & ~served, idx_q + 4'd1);
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs, pending-vector update and overflow detection
  always_comb begin
    accept     = (state_q == HOLD) && bus.out_ready;
    served     = accept ? (16'h0001 << idx_q) : 16'h0000;
    // A new request on a bit being served this cycle re-arms it.
    pending_d  = (pending_q & ~served) | bus.req_in;
    overflow_d = |(bus.req_in & pending_q & ~served);
  end

  assign bus.idx_out   = idx_q;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.pending   = pending_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: doc/req_index_encoder.md
REQ_INDEX_ENCODER -- requirements
Module: req_index_encoder

Interface
REQ-001 Parameter ROT_START, default 4'd0, SHALL be the round-robin pointer value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 req_in  input  16  SHALL carry request pulses, one bit per requester, sampled every cycle.
REQ-005 out_ready  input  1  SHALL be the consumer ready for idx_out.
REQ-006 idx_out  output  4  SHALL carry the binary index of the granted requester.
REQ-007 out_valid  output  1  SHALL qualify idx_out.
REQ-008 pending  output  16  SHALL expose the registered pending-request vector.
REQ-009 overflow  output  1  SHALL be a one-cycle pulse flagging a lost (merged) request.

Function
REQ-010 The block SHALL have two states: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-011 Handshake accept SHALL occur in a cycle with out_valid=1 and out_ready=1.
REQ-012 served SHALL be the one-hot of idx_out during accept, else 16'h0000.
REQ-013 pending SHALL update each cycle as (pending & ~served) | req_in.
REQ-014 A req_in bit and a served bit for the same requester in one cycle SHALL leave that bit set.
REQ-015 overflow SHALL be 1 the cycle after any req_in bit hits an already-pending bit that is not being served that cycle.
REQ-016 In IDLE with pending != 0, the block SHALL load idx_out with the first set pending bit at or above ptr, searching upward with wrap 15->0, and enter HOLD.
REQ-017 In IDLE with pending == 0, the block SHALL remain in IDLE; idx_out holds its last value.
REQ-018 Latency: req_in bit set at edge t SHALL appear in pending after edge t+1 and at out_valid after edge t+2 when idle with no other pending bits.
REQ-019 In HOLD without accept, idx_out and out_valid SHALL stay stable.
REQ-020 On accept, ptr SHALL become (idx_out + 1) mod 16; 15 wraps to 0.
REQ-021 On accept without RRE_BACK_TO_BACK_EN, the block SHALL return to IDLE (one bubble cycle).
REQ-022 idx_out SHALL only be a granted index of a bit set in pending at the time it was loaded.
REQ-023 Each pending bit SHALL be granted within 16 accepts (round-robin fairness).

Reset
REQ-024 With rst=1 at an edge: pending=16'h0000, out_valid=0, idx_out=4'h0, overflow=0, ptr=ROT_START, state=IDLE.
REQ-025 Reset mid-HOLD SHALL drop the in-flight grant, with no accept recorded; req_in during reset SHALL be discarded.

Configuration
REQ-026 Macro RRE_BACK_TO_BACK_EN defined: on accept, if (pending & ~served) != 0, idx_out SHALL load the next index searched from the new ptr over that vector, keeping HOLD (one grant per cycle).
REQ-027 Macro RRE_BACK_TO_BACK_EN undefined: REQ-021 applies; REQ-026 logic SHALL be absent.

Verification
REQ-028 Reset, req_in=16'h0008 one cycle, out_ready=1 -> out_valid=1, idx_out=3 two edges later; pending=0 after accept.
REQ-029 req_in=16'h8001 one cycle, ptr=0, out_ready=1 -> grants 0 then 15; with macro on consecutive cycles, without macro separated by one idle cycle.
REQ-030 ptr=15 via grant 14, then pending=16'h4001 -> next grant 0 (wrap), then 14.
REQ-031 Hold out_ready=0 for 5 cycles with idx_out=5 -> idx_out, out_valid stable; req_in=16'h0020 again -> overflow=1 one cycle.
REQ-032 Accept idx 7 while req_in=16'h0080 -> bit 7 remains pending, no overflow, granted again later.
REQ-033 rst asserted during HOLD -> next cycle out_valid=0, pending=0, ptr=ROT_START.
